// File: rtl/adder_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbitrated adder: output buffer state
// encoding and default fixed-point operand widths.
package adder_rr_arbiter_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int unsigned DEF_I_WIDTH = 8;
  localparam int unsigned DEF_F_WIDTH = 8;

endpackage

// File: rtl/adder_rr_arbiter_adder.sv
// Shared combinational adder: signed add with carry out of a W+1-bit
// sign-extended sum, or pass-through of operand A when disabled.
module adder_rr_arbiter_adder
  import adder_rr_arbiter_pkg::*;
#(
  parameter int unsigned W = DEF_I_WIDTH + DEF_F_WIDTH
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         en_adder_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o
);

  logic [W:0] w_full;

  always_comb begin
    w_full = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    if (en_adder_i) begin
      {carry_o, sum_o} = w_full;
    end else begin
      sum_o   = a_i;
      carry_o = 1'b0;
    end
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// N_REQ requesters share one adder through a round-robin arbiter feeding a
// single-entry output buffer that supports one result per cycle.
module adder_rr_arbiter
  import adder_rr_arbiter_pkg::*;
#(
  parameter int unsigned I_WIDTH = DEF_I_WIDTH,
  parameter int unsigned F_WIDTH = DEF_F_WIDTH,
  parameter int unsigned N_REQ   = 4,
  localparam int unsigned W      = I_WIDTH + F_WIDTH,
  localparam int unsigned ID_W   = $clog2(N_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  output logic [N_REQ-1:0]   req_ready_o,
  input  logic [N_REQ*W-1:0] req_a_i,
  input  logic [N_REQ*W-1:0] req_b_i,
  input  logic [N_REQ-1:0]   req_add_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [W-1:0]       out_sum_o,
  output logic               out_carry_o,
  output logic [ID_W-1:0]    out_id_o
);

  state_e            r_state;
  state_e            w_state_d;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic [W-1:0]      r_sum;
  logic              r_carry;
  logic [ID_W-1:0]   r_id;

  logic [N_REQ-1:0]  w_rot;
  logic              w_found;
  logic [ID_W-1:0]   w_off;
  logic [ID_W-1:0]   w_gnt_idx;
  logic              w_can_grant;
  logic              w_grant;

  logic [W-1:0]      w_a;
  logic [W-1:0]      w_b;
  logic              w_add;
  logic [W-1:0]      w_sum;
  logic              w_carry;

  // Reduce a value in [0, 2*N_REQ-2] modulo N_REQ.
  function automatic logic [ID_W-1:0] rr_wrap(input logic [ID_W:0] x);
    if (x >= (ID_W+1)'(N_REQ)) begin
      return ID_W'(x - (ID_W+1)'(N_REQ));
    end
    return x[ID_W-1:0];
  endfunction

  // Rotate so that the pointer position lands at bit 0.
  always_comb begin
    w_rot = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_rot[i] = req_valid_i[rr_wrap({1'b0, r_ptr} + (ID_W+1)'(i))];
    end
  end

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_off   = ID_W'(i);
      end
    end
  end

  // Rotate back to an absolute requester index.
  assign w_gnt_idx   = rr_wrap({1'b0, r_ptr} + {1'b0, w_off});
  assign w_ptr_nxt   = rr_wrap({1'b0, w_gnt_idx} + (ID_W+1)'(1));
  assign w_can_grant = !rst_i && ((r_state == ST_EMPTY) || out_ready_i);
  assign w_grant     = w_can_grant && w_found;

  always_comb begin
    req_ready_o = '0;
    if (w_grant) begin
      req_ready_o[w_gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_add = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_gnt_idx == ID_W'(k)) begin
        w_a   = req_a_i[k*W +: W];
        w_b   = req_b_i[k*W +: W];
        w_add = req_add_i[k];
      end
    end
  end

  adder_rr_arbiter_adder #(
    .W (W)
  ) u_adder (
    .a_i        (w_a),
    .b_i        (w_b),
    .en_adder_i (w_add),
    .sum_o      (w_sum),
    .carry_o    (w_carry)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_grant) begin
          w_state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready_i && !w_grant) begin
          w_state_d = ST_EMPTY;
        end
      end
      default: w_state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
      r_ptr   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_grant) begin
        r_ptr   <= w_ptr_nxt;
        r_sum   <= w_sum;
        r_carry <= w_carry;
        r_id    <= w_gnt_idx;
      end
    end
  end

  assign out_valid_o = (r_state == ST_FULL);
  assign out_sum_o   = r_sum;
  assign out_carry_o = r_carry;
  assign out_id_o    = r_id;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Randomized scoreboard bench for adder_rr_arbiter with directed corner cases.
module tb_adder_rr_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic [1:0]   id;
  } res_t;

  logic           clk = 1'b0;
  logic           rst_i = 1'b1;
  logic [N-1:0]   req_valid_i = '0;
  logic [N-1:0]   req_ready_o;
  logic [N*W-1:0] req_a_i = '0;
  logic [N*W-1:0] req_b_i = '0;
  logic [N-1:0]   req_add_i = '0;
  logic           out_valid_o;
  logic           out_ready_i = 1'b0;
  logic [W-1:0]   out_sum_o;
  logic           out_carry_o;
  logic [1:0]     out_id_o;

  int   total = 0;
  int   bad = 0;
  int   p = 0;
  bit   rst_prev = 1'b0;
  res_t q[$];

  adder_rr_arbiter #(
    .I_WIDTH (8),
    .F_WIDTH (8),
    .N_REQ   (N)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .req_add_i   (req_add_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_sum_o   (out_sum_o),
    .out_carry_o (out_carry_o),
    .out_id_o    (out_id_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: plain integer add, low 17 bits give {carry, sum}.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic add, input int id);
    res_t        r;
    int          sa;
    int          sb;
    logic [31:0] rv;
    sa = $signed(a);
    sb = $signed(b);
    rv = sa + sb;
    if (add) begin
      r.sum   = rv[W-1:0];
      r.carry = rv[W];
    end else begin
      r.sum   = a;
      r.carry = 1'b0;
    end
    r.id = 2'(id);
    return r;
  endfunction

  function automatic logic [N*W-1:0] put(input int k, input logic [W-1:0] x);
    logic [N*W-1:0] r;
    r = '0;
    r[k*W +: W] = x;
    return r;
  endfunction

  // One clock: drive after the edge, check arbitration just after the falling edge.
  task automatic step(input bit rst, input logic [N-1:0] v, input logic [N*W-1:0] a,
                      input logic [N*W-1:0] b, input logic [N-1:0] add, input bit ordy);
    int           win;
    logic [N-1:0] exp_rdy;
    @(posedge clk);
    #1;
    rst_i       = rst;
    req_valid_i = v;
    req_a_i     = a;
    req_b_i     = b;
    req_add_i   = add;
    out_ready_i = ordy;
    #5;
    if (rst_prev) begin
      chk("rst_valid", out_valid_o, 0);
      chk("rst_sum", out_sum_o, 0);
      chk("rst_carry", out_carry_o, 0);
      chk("rst_id", out_id_o, 0);
    end
    rst_prev = rst;
    exp_rdy  = '0;
    if (rst) begin
      q.delete();
      p = 0;
    end else if (ordy || q.size() == 0) begin
      win = -1;
      for (int i = 0; i < N; i++) begin
        if (win < 0 && v[(p + i) % N]) win = (p + i) % N;
      end
      if (win >= 0) begin
        exp_rdy[win] = 1'b1;
        q.push_back(model(a[win*W +: W], b[win*W +: W], add[win], win));
        p = (win + 1) % N;
      end
    end
    chk("req_ready", req_ready_o, exp_rdy);
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, '0, '0, '0, '0, ordy);
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] s, input logic c,
                            input logic [1:0] id);
    chk({name, "_valid"}, out_valid_o, 1);
    chk({name, "_sum"}, out_sum_o, s);
    chk({name, "_carry"}, out_carry_o, c);
    chk({name, "_id"}, out_id_o, id);
  endtask

  // Monitor: whenever the DUT presents a result, it must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (q.size() == 0) begin
          chk("idle_valid", out_valid_o, 0);
        end else begin
          chk("mon_valid", out_valid_o, 1);
          chk("mon_sum", out_sum_o, q[0].sum);
          chk("mon_carry", out_carry_o, q[0].carry);
          chk("mon_id", out_id_o, q[0].id);
          if (out_ready_i) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (3) step(1'b1, '0, '0, '0, '0, 1'b0);
    idle(1'b1);

    step(1'b0, 4'b0100, put(2, 16'h0180), put(2, 16'h0080), 4'b0100, 1'b1);
    idle(1'b1);
    expect_out("single", 16'h0200, 1'b0, 2'd2);

    step(1'b0, 4'b0001, put(0, 16'hFF00), put(0, 16'hFF00), 4'b0001, 1'b1);
    idle(1'b1);
    expect_out("neg_carry", 16'hFE00, 1'b1, 2'd0);
    step(1'b0, 4'b0010, put(1, 16'h7F00), put(1, 16'h0200), 4'b0010, 1'b1);
    idle(1'b1);
    expect_out("ovf", 16'h8100, 1'b0, 2'd1);
    step(1'b0, 4'b1000, put(3, 16'h1234), put(3, 16'h5555), 4'b0000, 1'b1);
    idle(1'b1);
    expect_out("pass", 16'h1234, 1'b0, 2'd3);

    // All requesters valid from reset: strict rotation 0,1,2,3,...
    step(1'b1, '0, '0, '0, '0, 1'b0);
    repeat (8) step(1'b0, 4'hF, {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom), 1'b1);

    // Backpressure with requesters 1 and 3 pending, then release.
    repeat (5) step(1'b0, 4'b1010, {$urandom, $urandom}, {$urandom, $urandom}, 4'hF, 1'b0);
    step(1'b0, 4'b1010, {$urandom, $urandom}, {$urandom, $urandom}, 4'hF, 1'b1);
    step(1'b0, 4'b1010, {$urandom, $urandom}, {$urandom, $urandom}, 4'hF, 1'b1);
    chk("bp_second_id", out_id_o, 1);
    idle(1'b1);
    chk("bp_third_id", out_id_o, 3);
    idle(1'b1);

    // Reset while FULL discards the pending result.
    step(1'b0, 4'b0001, put(0, 16'h0101), put(0, 16'h0202), 4'b0001, 1'b0);
    step(1'b0, 4'b0001, put(0, 16'h0101), put(0, 16'h0202), 4'b0001, 1'b0);
    step(1'b1, 4'b0001, put(0, 16'h0101), put(0, 16'h0202), 4'b0001, 1'b0);
    step(1'b0, 4'hF, {$urandom, $urandom}, {$urandom, $urandom}, 4'hF, 1'b1);
    chk("post_rst_grant0", req_ready_o, 4'b0001);
    idle(1'b1);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), 4'($urandom), {$urandom, $urandom},
           {$urandom, $urandom}, 4'($urandom), ($urandom_range(0, 3) != 0));
    end

    repeat (3) idle(1'b1);
    chk("drain_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
